div_sequencer: RTL and testbench



---
 rtl/multdiv_pkg.sv | 15 +
 rtl/div_sign_fix.sv | 17 +
 rtl/div_sequencer.sv | 171 +++++++++++++++++
 tb/tb_div_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: divider state encoding, width and counter sizing.
package multdiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate. With i_negate tied to the operand sign bit it
// yields the unsigned magnitude (|INT_MIN| comes out exactly as 0x80..0 when read unsigned);
// with i_negate tied to a latched sign flag it restores the sign of a result.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_negate,
  output logic [WIDTH-1:0] o_value
);

  // Negate or pass through, truncated to WIDTH bits
  always_comb begin
    o_value = i_negate ? -i_value : i_value;
  end

endmodule

// File: rtl/div_sequencer.sv
// Iterative signed divider: one restoring shift/subtract step per cycle over operand
// magnitudes, followed by a sign-correction cycle and a one-cycle result_valid pulse.
module div_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  divState_t r_state;
  divState_t w_nextState;

  logic [2*WIDTH-1:0] r_aq;
  logic [WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]   r_count;
  logic               r_qNeg;
  logic               r_rNeg;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_divByZero;
  logic               r_overflow;

  logic [WIDTH-1:0]   w_absDividend;
  logic [WIDTH-1:0]   w_absDivisor;
  logic [WIDTH-1:0]   w_quotFixed;
  logic [WIDTH-1:0]   w_remFixed;
  logic [2*WIDTH-1:0] w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_aNext;
  logic [WIDTH-1:0]   w_qNext;

  div_sign_fix #(.WIDTH(WIDTH)) u_absDividend (
    .i_value (dividend),
    .i_negate(dividend[WIDTH-1]),
    .o_value (w_absDividend)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_absDivisor (
    .i_value (divisor),
    .i_negate(divisor[WIDTH-1]),
    .o_value (w_absDivisor)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fixQuotient (
    .i_value (r_aq[WIDTH-1:0]),
    .i_negate(r_qNeg),
    .o_value (w_quotFixed)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fixRemainder (
    .i_value (r_aq[2*WIDTH-1:WIDTH]),
    .i_negate(r_rNeg),
    .o_value (w_remFixed)
  );

  // One restoring step: shift AQ left, trial-subtract M from the upper half one bit wider
  // so the borrow shows up as the sign bit, then keep or restore A and set the quotient bit.
  always_comb begin
    w_shift = r_aq << 1;
    w_trial = {1'b0, w_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_m};
    w_aNext = w_trial[WIDTH] ? w_shift[2*WIDTH-1:WIDTH] : w_trial[WIDTH-1:0];
    w_qNext = w_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~w_trial[WIDTH]};
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; flush overrides every other transition, a zero divisor skips iteration
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (divisor == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        if (r_count == LAST_STEP) begin
          w_nextState = FIX;
        end
      end
      FIX:     w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (flush) begin
      w_nextState = IDLE;
    end
  end

  // Datapath: operand load, iteration, sign correction; results hold across flush and idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_aq        <= '0;
      r_m         <= '0;
      r_count     <= '0;
      r_qNeg      <= 1'b0;
      r_rNeg      <= 1'b0;
      r_ovf       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quotient  <= '0;
              r_remainder <= dividend;
              r_divByZero <= 1'b1;
              r_overflow  <= 1'b0;
            end else begin
              r_aq    <= {{WIDTH{1'b0}}, w_absDividend};
              r_m     <= w_absDivisor;
              r_count <= '0;
              r_qNeg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_rNeg  <= dividend[WIDTH-1];
              r_ovf   <= (dividend == MIN_VAL) && (divisor == '1);
            end
          end
        end
        ITER: begin
          r_aq    <= {w_aNext, w_qNext};
          r_count <= r_count + 1'b1;
        end
        FIX: begin
          r_quotient  <= w_quotFixed;
          r_remainder <= w_remFixed;
          r_overflow  <= r_ovf;
          r_divByZero <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy         = (r_state == ITER) || (r_state == FIX);
  assign result_valid = (r_state == DONE);
  assign quotient     = r_quotient;
  assign remainder    = r_remainder;
  assign div_by_zero  = r_divByZero;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: sign combinations, divide-by-zero, overflow,
// ignored start while busy, flush and asynchronous reset mid-operation.
module tb_div_sequencer;
  import multdiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int assertCount = 0;
  int failCount   = 0;

  div_sequencer #(.WIDTH(DIV_WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .flush       (flush),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .result_valid(result_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request for a single clock; returns at the falling edge after the sampling edge
  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clock);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Count rising edges after the sampling edge until result_valid, tallying busy cycles;
  // optionally fires a stray start request after injectAt edges
  task automatic waitValid(input int injectAt, output int edges, output int busyCycles);
    edges      = 0;
    busyCycles = 0;
    while (!result_valid && edges < 100) begin
      if (busy) busyCycles++;
      if (edges == injectAt) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd9;
      end
      @(posedge clock);
      edges++;
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  // Full request with result, flag, latency and pulse-width checks
  task automatic runDivide(input string name, input logic [31:0] dvd, input logic [31:0] dvs,
                           input logic [31:0] expQ, input logic [31:0] expR,
                           input logic expDz, input logic expOvf, input int expEdges,
                           input int injectAt);
    int edges;
    int busyCycles;
    applyStimulus(dvd, dvs);
    waitValid(injectAt, edges, busyCycles);
    checkOutput({name, ".valid"},     32'(result_valid), 32'd1);
    checkOutput({name, ".latency"},   32'(edges),        32'(expEdges));
    checkOutput({name, ".busyCount"}, 32'(busyCycles),   32'(expEdges));
    checkOutput({name, ".quotient"},  quotient,          expQ);
    checkOutput({name, ".remainder"}, remainder,         expR);
    checkOutput({name, ".divByZero"}, 32'(div_by_zero),  32'(expDz));
    checkOutput({name, ".overflow"},  32'(overflow),     32'(expOvf));
    @(posedge clock);
    @(negedge clock);
    checkOutput({name, ".pulseEnd"},  32'(result_valid), 32'd0);
    checkOutput({name, ".holdQ"},     quotient,          expQ);
  endtask

  initial begin
    int sawValid;
    reset_n  = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    checkOutput("reset.busy",      32'(busy),         32'd0);
    checkOutput("reset.valid",     32'(result_valid), 32'd0);
    checkOutput("reset.quotient",  quotient,          32'd0);
    checkOutput("reset.remainder", remainder,         32'd0);
    checkOutput("reset.divByZero", 32'(div_by_zero),  32'd0);
    checkOutput("reset.overflow",  32'(overflow),     32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Latency is counted in rising edges after the edge that samples start
    runDivide("pos7by2",  32'd7,          32'd2,          32'd3,          32'd1,          1'b0, 1'b0, 33, -1);
    runDivide("neg7by2",  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 33, -1);
    runDivide("pos7byN2", 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 33, -1);
    runDivide("neg7byN2", 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0, 33, -1);
    runDivide("maxBy1",   32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 1'b0, 33, -1);
    runDivide("by0",      32'd5,          32'd0,          32'd0,          32'd5,          1'b1, 1'b0, 0,  -1);
    runDivide("minByN1",  DIV_INT_MIN,    32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 33, -1);
    runDivide("ignStart", 32'd50,         32'd3,          32'd16,         32'd2,          1'b0, 1'b0, 33, 10);
    runDivide("afterIgn", 32'd9,          32'd4,          32'd2,          32'd1,          1'b0, 1'b0, 33, -1);

    // Flush part-way through: busy drops, no result, previous results remain
    applyStimulus(32'd1000, 32'd3);
    repeat (15) begin
      @(posedge clock);
      @(negedge clock);
    end
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    checkOutput("flush.busy",     32'(busy), 32'd0);
    checkOutput("flush.holdQ",    quotient,  32'd2);
    checkOutput("flush.holdR",    remainder, 32'd1);
    sawValid = 0;
    repeat (40) begin
      @(posedge clock);
      @(negedge clock);
      if (result_valid) sawValid = 1;
    end
    checkOutput("flush.noValid", 32'(sawValid), 32'd0);
    runDivide("postFlush", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, -1);
    runDivide("minByN1b",  DIV_INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 33, -1);

    // Asynchronous reset part-way through clears everything without waiting for a clock
    applyStimulus(32'd1000, 32'd3);
    repeat (20) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midReset.busy",      32'(busy),         32'd0);
    checkOutput("midReset.valid",     32'(result_valid), 32'd0);
    checkOutput("midReset.quotient",  quotient,          32'd0);
    checkOutput("midReset.remainder", remainder,         32'd0);
    checkOutput("midReset.overflow",  32'(overflow),     32'd0);
    #2;
    reset_n = 1'b1;
    runDivide("postReset", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
